// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: byte/half/word loads and stores over a
// req/ack bus, stalling upstream while an access is outstanding.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        flush,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t      state;
    logic [7:0]  cnt;

    logic        acc_load;
    logic        acc_unsigned;
    logic        acc_kill;
    logic        acc_rw;
    logic [1:0]  acc_size;
    logic [1:0]  acc_off;
    logic [4:0]  acc_rd;

    logic        mem_op;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        start;
    logic        timed_out;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        mem_op     = in_valid & (in_mem_read | in_mem_write);
        is_byte    = (in_size == 2'b00);
        is_half    = (in_size == 2'b01);
        misaligned = (is_half & in_alu_result[0])
                   | (~is_byte & ~is_half & (in_alu_result[1:0] != 2'b00));
        start      = mem_op & ~misaligned & ~flush;
        timed_out  = (cnt == 8'(TIMEOUT - 1));
    end

    // In BUSY the upstream stays frozen until ack, except in the timeout cycle
    // where the access is abandoned and the pipeline is released.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = start;
            BUSY:    stall = ~dmem_ack & ~timed_out;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = in_store_data;
        case (in_size)
            2'b00: begin
                be_next    = 4'b0001 << in_alu_result[1:0];
                wdata_next = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {in_alu_result[1], 1'b0};
                wdata_next = {2{in_store_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = in_store_data;
            end
        endcase
    end

    always_comb begin
        load_byte = dmem_rdata[7:0];
        case (acc_off)
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = acc_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (acc_size)
            2'b00:   load_data = {{24{~acc_unsigned & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{~acc_unsigned & load_half[15]}}, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            acc_load     <= 1'b0;
            acc_unsigned <= 1'b0;
            acc_kill     <= 1'b0;
            acc_rw       <= 1'b0;
            acc_size     <= '0;
            acc_off      <= '0;
            acc_rd       <= '0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    dmem_req <= 1'b0;
                    if (!mem_op) begin
                        wb_valid     <= in_valid & ~flush;
                        wb_data      <= in_alu_result;
                        wb_rd        <= in_rd;
                        wb_reg_write <= in_valid & in_reg_write & ~flush;
                    end else if (misaligned) begin
                        misalign_err <= 1'b1;
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else if (flush) begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else begin
                        state        <= BUSY;
                        dmem_req     <= 1'b1;
                        dmem_we      <= in_mem_write;
                        dmem_addr    <= {in_alu_result[31:2], 2'b00};
                        dmem_be      <= be_next;
                        dmem_wdata   <= wdata_next;
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                        acc_load     <= in_mem_read;
                        acc_unsigned <= in_unsigned;
                        acc_kill     <= 1'b0;
                        acc_rw       <= in_reg_write;
                        acc_size     <= in_size;
                        acc_off      <= in_alu_result[1:0];
                        acc_rd       <= in_rd;
                    end
                end
                BUSY: begin
                    // A flush seen in any BUSY cycle kills write-back but the
                    // bus transaction still runs to completion.
                    acc_kill <= acc_kill | flush;
                    if (dmem_ack) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        dmem_req     <= 1'b0;
                        wb_valid     <= ~acc_kill & ~flush;
                        wb_rd        <= acc_rd;
                        wb_reg_write <= acc_load & acc_rw & ~acc_kill & ~flush;
                        if (acc_load) begin
                            wb_data <= load_data;
                        end
                    end else if (timed_out) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        dmem_req     <= 1'b0;
                        bus_err      <= 1'b1;
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, loads, stores, misalign,
// timeout, reset during an access and flush during a store.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        flush;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_err;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    int          n_stall;
    int          n_req;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        in_valid      = 1'b0;
        in_alu_result = '0;
        in_store_data = '0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_size       = 2'b00;
        in_unsigned   = 1'b0;
        in_rd         = '0;
        in_reg_write  = 1'b0;
        flush         = 1'b0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
    endtask

    task automatic set_op(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic rw);
        in_valid      = 1'b1;
        in_mem_read   = rd_op;
        in_mem_write  = wr_op;
        in_alu_result = addr;
        in_store_data = sdata;
        in_size       = size;
        in_unsigned   = uns;
        in_rd         = rd;
        in_reg_write  = rw;
    endtask

    // Starts just after an edge with the instruction on the inputs; returns
    // just after the edge where the access (or its absence) has resolved.
    // ack_after < 0 means the memory never answers.
    task automatic run_access(input int ack_after, input logic [31:0] rdata);
        int busy = 0;
        bit done = 0;
        n_stall = 0;
        n_req   = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (dmem_req) begin
                n_req++;
                cap_we    = dmem_we;
                cap_addr  = dmem_addr;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
                if (busy == ack_after) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                busy++;
            end
            #1;
            if (stall) n_stall++;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (!dmem_req && (n_req > 0 || cyc == 0)) done = 1;
        end
        if (!done) check("access_bound", 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   dmem_req, 0);
        check("rst_wbv",   wb_valid, 0);
        check("rst_wbrw",  wb_reg_write, 0);
        check("rst_addr",  dmem_addr, 0);
        check("rst_be",    dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_errs",  {misalign_err, bus_err}, 0);
        rst_n = 1'b1;

        // ALU passthrough
        set_op(0, 0, 32'h0000_002A, 0, 2'b10, 0, 5'd5, 1);
        #1;
        check("pt_stall", stall, 0);
        tick();
        check("pt_wbv",  wb_valid, 1);
        check("pt_data", wb_data, 32'h0000_002A);
        check("pt_rd",   wb_rd, 5);
        check("pt_rw",   wb_reg_write, 1);
        set_idle();

        // ack in IDLE without a request is ignored
        dmem_ack = 1'b1;
        #1;
        check("zack_stall", stall, 0);
        tick();
        check("zack_req", dmem_req, 0);
        check("zack_wbv", wb_valid, 0);
        set_idle();

        // LB at 0x1003, ack in the 4th BUSY cycle
        set_op(1, 0, 32'h0000_1003, 0, 2'b00, 0, 5'd7, 1);
        run_access(3, 32'h8011_2233);
        set_idle();
        check("lb_stall", n_stall, 4);
        check("lb_req",   n_req, 4);
        check("lb_be",    cap_be, 4'b1000);
        check("lb_addr",  cap_addr, 32'h0000_1000);
        check("lb_we",    cap_we, 0);
        check("lb_data",  wb_data, 32'hFFFF_FF80);
        check("lb_wbv",   wb_valid, 1);
        check("lb_rd",    wb_rd, 7);
        check("lb_rw",    wb_reg_write, 1);

        // LBU same address
        set_op(1, 0, 32'h0000_1003, 0, 2'b00, 1, 5'd8, 1);
        run_access(3, 32'h8011_2233);
        set_idle();
        check("lbu_data", wb_data, 32'h0000_0080);

        // LH lane 0 and LHU lane 2
        set_op(1, 0, 32'h0000_5000, 0, 2'b01, 0, 5'd9, 1);
        run_access(0, 32'h1234_8001);
        set_idle();
        check("lh_be",   cap_be, 4'b0011);
        check("lh_data", wb_data, 32'hFFFF_8001);
        set_op(1, 0, 32'h0000_5002, 0, 2'b01, 1, 5'd9, 1);
        run_access(1, 32'h9ABC_0000);
        set_idle();
        check("lhu_data", wb_data, 32'h0000_9ABC);

        // LW ignores unsigned; size 11 behaves as word
        set_op(1, 0, 32'h0000_6004, 0, 2'b11, 1, 5'd10, 1);
        run_access(0, 32'hDEAD_BEEF);
        set_idle();
        check("lw_be",   cap_be, 4'b1111);
        check("lw_data", wb_data, 32'hDEAD_BEEF);

        // SH at 0x2002 (reg_write set but a store never writes back)
        set_op(0, 1, 32'h0000_2002, 32'h1234_BEEF, 2'b01, 0, 5'd11, 1);
        run_access(0, 32'h0);
        set_idle();
        check("sh_stall", n_stall, 1);
        check("sh_we",    cap_we, 1);
        check("sh_be",    cap_be, 4'b1100);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_addr",  cap_addr, 32'h0000_2000);
        check("sh_wbv",   wb_valid, 1);
        check("sh_rw",    wb_reg_write, 0);

        // misaligned LW at 0x3001
        set_op(1, 0, 32'h0000_3001, 0, 2'b10, 0, 5'd12, 1);
        run_access(0, 32'h0);
        check("mis_req",   n_req, 0);
        check("mis_stall", n_stall, 0);
        check("mis_err",   misalign_err, 1);
        check("mis_wbv",   wb_valid, 0);
        set_idle();
        tick();
        check("mis_pulse", misalign_err, 0);

        // load with flush in IDLE is a bubble
        set_op(1, 0, 32'h0000_7000, 0, 2'b10, 0, 5'd13, 1);
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 0);
        tick();
        check("fl_req", dmem_req, 0);
        check("fl_wbv", wb_valid, 0);
        set_idle();

        // timeout with TIMEOUT=4
        set_op(1, 0, 32'h0000_8000, 0, 2'b10, 0, 5'd14, 1);
        run_access(-1, 32'h0);
        set_idle();
        check("to_req",   n_req, 4);
        check("to_stall", n_stall, 4);
        check("to_err",   bus_err, 1);
        check("to_wbv",   wb_valid, 0);
        set_op(0, 0, 32'h0000_0055, 0, 2'b10, 0, 5'd15, 1);
        tick();
        check("to_pulse",   bus_err, 0);
        check("to_pt_data", wb_data, 32'h0000_0055);
        check("to_pt_rd",   wb_rd, 15);
        check("to_pt_wbv",  wb_valid, 1);
        set_idle();

        // reset in the middle of an access
        set_op(1, 0, 32'h0000_9008, 0, 2'b10, 0, 5'd16, 1);
        tick();
        check("rb_req", dmem_req, 1);
        tick();
        rst_n = 1'b0;
        set_idle();
        tick();
        check("rb_req0", dmem_req, 0);
        check("rb_addr", dmem_addr, 0);
        check("rb_be",   dmem_be, 0);
        check("rb_wbv",  wb_valid, 0);
        check("rb_data", wb_data, 0);
        rst_n = 1'b1;
        tick();
        check("rb_idle", dmem_req, 0);

        // flush during a byte store in BUSY
        set_op(0, 1, 32'h0000_4001, 32'h0000_00A5, 2'b00, 0, 5'd3, 0);
        tick();
        check("fs_req",   dmem_req, 1);
        check("fs_be",    dmem_be, 4'b0010);
        check("fs_wdata", dmem_wdata, 32'hA5A5_A5A5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fs_hold", dmem_req, 1);
        dmem_ack = 1'b1;
        #1;
        check("fs_stall", stall, 0);
        tick();
        set_idle();
        check("fs_done", dmem_req, 0);
        check("fs_wbv",  wb_valid, 0);
        check("fs_rw",   wb_reg_write, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit of the 5-stage pipeline, directly downstream of the EX-stage ALU. It consumes the EX/MEM-latched ALU result as the effective address and rs2 data as store data. It performs byte/half/word loads and stores over a req/ack data-memory bus, stalling the pipeline while an access is outstanding. It produces the registered MEM/WB fields: write-back data, destination register and write enable.

Parameters:
TIMEOUT, 16, max cycles waiting for dmem_ack before aborting with bus_err (range 2..255)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  EX/MEM slot holds a live instruction
in_alu_result  input  32  ALU result: address for mem ops, write-back data otherwise
in_store_data  input  32  rs2 value for stores
in_mem_read  input  1  load
in_mem_write  input  1  store (mutually exclusive with in_mem_read)
in_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
in_unsigned  input  1  zero-extend loads (LBU/LHU)
in_rd  input  5  destination register
in_reg_write  input  1  instruction writes rd
flush  input  1  kill the current instruction's write-back
stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 write, 0 read
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_be  output  4  byte enables, lane i = bits [8i+7:8i]
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  access complete (one-cycle pulse)
wb_valid  output  1  MEM/WB slot live
wb_data  output  32  load result or passthrough ALU result
wb_rd  output  5  destination register
wb_reg_write  output  1  write enable to WB (0 if killed or errored)
misalign_err  output  1  one-cycle pulse: misaligned access dropped
bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, timeout counter 0. dmem_req, dmem_we, wb_valid, wb_reg_write, misalign_err and bus_err are 0. dmem_addr, dmem_be, dmem_wdata, wb_data and wb_rd are 0. Reset during BUSY abandons the access; dmem_req is 0 after that edge.
- mem_op = in_valid & (in_mem_read | in_mem_write). misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM IDLE:
  - Non-mem op: 1-cycle passthrough at next edge: wb_valid=in_valid&~flush, wb_data=in_alu_result, wb_rd=in_rd, wb_reg_write=in_valid&in_reg_write&~flush.
  - mem_op & misaligned: no request. misalign_err=1 next cycle, wb_valid=0, wb_reg_write=0, no stall.
  - mem_op & aligned & ~flush: stall=1 this cycle. Next edge: go BUSY, dmem_req=1, dmem_addr/we/be/wdata latched, wb_valid=0.
  - mem_op & flush: treated as bubble, no request.
- FSM BUSY: dmem_req, addr, be, wdata and we are held stable. stall = ~dmem_ack. The counter increments each BUSY cycle without ack.
  - dmem_ack: next edge returns to IDLE with dmem_req=0. wb_valid=1 and wb_rd latched. For a load, wb_reg_write=in_reg_write and wb_data=extracted load. For a store, wb_reg_write=0. The upstream pipeline advances on the same edge (stall low).
  - Counter reaches TIMEOUT-1 without ack: next edge returns to IDLE, dmem_req=0, bus_err=1, wb_valid=0. stall is 0 in that final cycle.
  - flush during BUSY does not abort the access (stores must complete). It only forces wb_valid and wb_reg_write to 0 on completion.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- wdata: byte replicated to all 4 lanes, half to both halves, word as-is.
- Load extract (little-endian lanes):
  - byte: lane addr[1:0]
  - half: lanes {addr[1],0}
  - Sign-extend unless in_unsigned. Word loads ignore in_unsigned.
- Error pulses last exactly one cycle. A zero-cycle ack (ack without req) is ignored in IDLE.

Test Plan:
- ALU passthrough: in_alu_result=0x0000_002A, rd=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x2A, wb_rd=5, stall never 1.
- Byte load sign/zero: addr=0x1003, LB, dmem_rdata=0x80xx_xxxx, ack after 3 cycles → stall high 4 cycles, dmem_be=1000, wb_data=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- Half store: addr=0x2002, store_data=0x1234_BEEF → dmem_we=1, dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x2000, wb_reg_write=0.
- Misaligned word load addr=0x3001 → no dmem_req, misalign_err 1-cycle pulse, wb_valid=0, no stall.
- Timeout with TIMEOUT=4, no ack → dmem_req held exactly 4 cycles, bus_err pulse, FSM IDLE, next passthrough instruction completes normally.
- rst_n=0 mid-BUSY, then flush during a store in BUSY → reset drops req and clears all outputs. For the flushed store, the access completes on ack with wb_valid=0.
